// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// The controller takes the master side; the datapath takes the slave side.
interface multicycle_control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       RegWrite;
  logic       IllegalInstr;

  modport master (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
    output ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
    output RegWrite, IllegalInstr
  );

  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
    input  ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
    input  RegWrite, IllegalInstr
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main controller of the multi-cycle RV32I core: sequences each
// instruction and drives every datapath select and write enable.
module multicycle_control_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11
  } state_t;

  state_t state, next;

  logic       is_ld, is_st, is_r, is_i;
  logic       is_b, is_jal, is_lui;
  logic       illegal_q, illegal_d;
  logic       irw, memw, regw, pcu, br;
  logic       taken, adr;
  logic [1:0] res, sa, sb;
  logic [2:0] alu, alu_dec;

  assign is_ld  = bus.op == 7'b0000011;
  assign is_st  = bus.op == 7'b0100011;
  assign is_r   = bus.op == 7'b0110011;
  assign is_i   = bus.op == 7'b0010011;
  assign is_b   = bus.op == 7'b1100011;
  assign is_jal = bus.op == 7'b1101111;
  assign is_lui = bus.op == 7'b0110111;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= state_t'(RESET_STATE);
      illegal_q <= 1'b0;
    end else begin
      state     <= next;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    alu_dec = 3'b000;
    unique case (bus.funct3)
      3'b000:  alu_dec = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    unique case (bus.funct3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = ~bus.Zero;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next      = FETCH;
    illegal_d = 1'b0;
    irw       = 1'b0;
    memw      = 1'b0;
    regw      = 1'b0;
    pcu       = 1'b0;
    br        = 1'b0;
    adr       = 1'b0;
    res       = 2'b00;
    sa        = 2'b00;
    sb        = 2'b00;
    alu       = 3'b000;
    unique case (state)
      FETCH: begin
        sb   = 2'b10;
        res  = 2'b10;
        irw  = bus.MemReady;
        pcu  = bus.MemReady;
        next = bus.MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        sa = 2'b01;
        sb = 2'b01;
        unique case (1'b1)
          is_ld, is_st: next = MEMADR;
          is_r:         next = EXECUTER;
          is_i:         next = EXECUTEI;
          is_b:         next = BRANCH;
          is_jal:       next = JAL;
          is_lui:       next = LUI;
          default: begin
            next      = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        sa   = 2'b10;
        sb   = 2'b01;
        next = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr  = 1'b1;
        next = bus.MemReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        res  = 2'b01;
        regw = 1'b1;
      end
      MEMWRITE: begin
        adr  = 1'b1;
        memw = 1'b1;
        next = bus.MemReady ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        sa   = 2'b10;
        alu  = alu_dec;
        next = ALUWB;
      end
      EXECUTEI: begin
        sa   = 2'b10;
        sb   = 2'b01;
        alu  = alu_dec;
        next = ALUWB;
      end
      ALUWB: regw = 1'b1;
      BRANCH: begin
        sa  = 2'b10;
        alu = 3'b001;
        br  = 1'b1;
      end
      JAL: begin
        sa   = 2'b01;
        sb   = 2'b10;
        pcu  = 1'b1;
        next = ALUWB;
      end
      LUI: begin
        sa   = 2'b11;
        sb   = 2'b01;
        next = ALUWB;
      end
      default: next = FETCH;
    endcase
  end

  always_comb begin
    bus.ImmSrc = 3'b000;
    unique case (1'b1)
      is_st:   bus.ImmSrc = 3'b001;
      is_b:    bus.ImmSrc = 3'b010;
      is_jal:  bus.ImmSrc = 3'b011;
      is_lui:  bus.ImmSrc = 3'b100;
      default: bus.ImmSrc = 3'b000;
    endcase
  end

  // Enables are gated so nothing writes while reset is held
  assign bus.IRWrite      = irw & reset_n;
  assign bus.MemWrite     = memw & reset_n;
  assign bus.RegWrite     = regw & reset_n;
  assign bus.PCWrite      = reset_n & (pcu | (br & taken));
  assign bus.AdrSrc       = adr;
  assign bus.ResultSrc    = res;
  assign bus.ALUSrcA      = sa;
  assign bus.ALUSrcB      = sb;
  assign bus.ALUControl   = alu;
  assign bus.IllegalInstr = illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for the multi-cycle controller: vector table, hand-written
// corner sequences and random instructions against an instruction-level model.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic reset_n;

  multicycle_control_fsm_if bus();

  multicycle_control_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic       regw;
    logic       ill;
    logic       mr;
  } cyc_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         mw;
    int         cyc;
    int         regw;
    int         pcw;
    int         memw;
    logic [2:0] imm;
    logic [2:0] alu2;
    logic [1:0] sa2;
  } vec_t;

  cyc_t q[$];
  bit   ill_pend;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_LW, OP_I: return 3'b000;
      OP_SW:       return 3'b001;
      OP_B:        return 3'b010;
      OP_JAL:      return 3'b011;
      OP_LUI:      return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t mk(
    logic pcw, logic adr, logic memw, logic irw,
    logic [1:0] res, logic [1:0] sa, logic [1:0] sb,
    logic [2:0] alu, logic regw, logic mr);
    cyc_t r;
    r.pcw  = pcw;
    r.adr  = adr;
    r.memw = memw;
    r.irw  = irw;
    r.res  = res;
    r.sa   = sa;
    r.sb   = sb;
    r.alu  = alu;
    r.regw = regw;
    r.ill  = 1'b0;
    r.mr   = mr;
    return r;
  endfunction

  function automatic cyc_t sample();
    cyc_t r;
    r.pcw  = bus.PCWrite;
    r.adr  = bus.AdrSrc;
    r.memw = bus.MemWrite;
    r.irw  = bus.IRWrite;
    r.res  = bus.ResultSrc;
    r.sa   = bus.ALUSrcA;
    r.sb   = bus.ALUSrcB;
    r.alu  = bus.ALUControl;
    r.regw = bus.RegWrite;
    r.ill  = bus.IllegalInstr;
    r.mr   = 1'b0;
    return r;
  endfunction

  // Expected per-cycle trace of one instruction, built from its class
  task automatic build(input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z,
                       input int fw, input int mw);
    logic [2:0] alu;
    logic       tk;
    cyc_t       wb;
    q.delete();
    for (int j = 0; j < fw; j++)
      q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10,
                     3'b000, 1'b0, 1'b0));
    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10,
                   3'b000, 1'b0, 1'b1));
    q[0].ill = ill_pend;
    ill_pend = 1'b0;
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01,
                   3'b000, 1'b0, rb()));
    case (f3)
      3'b000:  alu = (op == OP_R && f7) ? 3'b001 : 3'b000;
      3'b010:  alu = 3'b101;
      3'b110:  alu = 3'b011;
      3'b111:  alu = 3'b010;
      default: alu = 3'b000;
    endcase
    tk = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
    wb = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
            3'b000, 1'b1, rb());
    if (op == OP_LW || op == OP_SW) begin
      q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01,
                     3'b000, 1'b0, rb()));
      for (int j = 0; j < mw; j++)
        q.push_back(mk(1'b0, 1'b1, op == OP_SW, 1'b0, 2'b00, 2'b00,
                       2'b00, 3'b000, 1'b0, 1'b0));
      q.push_back(mk(1'b0, 1'b1, op == OP_SW, 1'b0, 2'b00, 2'b00,
                     2'b00, 3'b000, 1'b0, 1'b1));
      if (op == OP_LW)
        q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00,
                       3'b000, 1'b1, rb()));
    end else if (op == OP_R) begin
      q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00,
                     alu, 1'b0, rb()));
      q.push_back(wb);
    end else if (op == OP_I) begin
      q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01,
                     alu, 1'b0, rb()));
      q.push_back(wb);
    end else if (op == OP_B) begin
      q.push_back(mk(tk, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00,
                     3'b001, 1'b0, rb()));
    end else if (op == OP_JAL) begin
      q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10,
                     3'b000, 1'b0, rb()));
      q.push_back(wb);
    end else if (op == OP_LUI) begin
      q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01,
                     3'b000, 1'b0, rb()));
      q.push_back(wb);
    end else begin
      ill_pend = 1'b1;
    end
  endtask

  task automatic run_q(input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z);
    cyc_t a, e;
    foreach (q[k]) begin
      bus.op       = op;
      bus.funct3   = f3;
      bus.funct7b5 = f7;
      bus.Zero     = z;
      bus.MemReady = q[k].mr;
      #1;
      e    = q[k];
      e.mr = 1'b0;
      a    = sample();
      chk("cycle", 32'(a), 32'(e));
      chk("imm_rand", 32'(bus.ImmSrc), 32'(imm_of(op)));
      @(negedge clk);
    end
  endtask

  // Runs one vector from a FETCH cycle; stops in the next FETCH cycle
  task automatic run_vec(input vec_t v, input int idx);
    int         cyc, regw, pcw, memw;
    bit         imm_ok, done, prevf, f;
    logic [2:0] alu2;
    logic [1:0] sa2;
    cyc = 0; regw = 0; pcw = 0; memw = 0;
    imm_ok = 1'b1; done = 1'b0; prevf = 1'b1;
    alu2 = 3'bxxx; sa2 = 2'bxx;
    for (int i = 0; i < 40 && !done; i++) begin
      bus.op       = v.op;
      bus.funct3   = v.f3;
      bus.funct7b5 = v.f7;
      bus.Zero     = v.z;
      bus.MemReady = !(i >= 3 && i < 3 + v.mw);
      #1;
      f = bus.ResultSrc == 2'b10;
      if (i == 2) begin
        alu2 = bus.ALUControl;
        sa2  = bus.ALUSrcA;
      end
      if (i > 0 && f && !prevf) begin
        cyc  = i;
        done = 1'b1;
      end else begin
        regw += int'(bus.RegWrite);
        pcw  += int'(bus.PCWrite);
        memw += int'(bus.MemWrite);
        if (bus.ImmSrc !== v.imm) imm_ok = 1'b0;
        @(negedge clk);
      end
      prevf = f;
    end
    chk($sformatf("vec%0d_cycles", idx), 32'(cyc), 32'(v.cyc));
    chk($sformatf("vec%0d_regw", idx), 32'(regw), 32'(v.regw));
    chk($sformatf("vec%0d_pcw", idx), 32'(pcw), 32'(v.pcw));
    chk($sformatf("vec%0d_memw", idx), 32'(memw), 32'(v.memw));
    chk($sformatf("vec%0d_imm", idx), 32'(imm_ok), 32'd1);
    chk($sformatf("vec%0d_alu", idx), 32'(alu2), 32'(v.alu2));
    chk($sformatf("vec%0d_srca", idx), 32'(sa2), 32'(v.sa2));
  endtask

  vec_t vt[$];

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z;
    int         sel;

    vt = '{
      '{OP_LW,  3'b010, 1'b0, 1'b0, 3, 8, 1, 1, 0, 3'b000, 3'b000, 2'b10},
      '{OP_LW,  3'b010, 1'b0, 1'b0, 0, 5, 1, 1, 0, 3'b000, 3'b000, 2'b10},
      '{OP_SW,  3'b010, 1'b0, 1'b0, 0, 4, 0, 1, 1, 3'b001, 3'b000, 2'b10},
      '{OP_SW,  3'b010, 1'b0, 1'b0, 2, 6, 0, 1, 3, 3'b001, 3'b000, 2'b10},
      '{OP_R,   3'b000, 1'b1, 1'b0, 0, 4, 1, 1, 0, 3'b000, 3'b001, 2'b10},
      '{OP_R,   3'b000, 1'b0, 1'b0, 0, 4, 1, 1, 0, 3'b000, 3'b000, 2'b10},
      '{OP_I,   3'b000, 1'b1, 1'b0, 0, 4, 1, 1, 0, 3'b000, 3'b000, 2'b10},
      '{OP_R,   3'b010, 1'b0, 1'b0, 0, 4, 1, 1, 0, 3'b000, 3'b101, 2'b10},
      '{OP_I,   3'b110, 1'b0, 1'b0, 0, 4, 1, 1, 0, 3'b000, 3'b011, 2'b10},
      '{OP_R,   3'b111, 1'b0, 1'b0, 0, 4, 1, 1, 0, 3'b000, 3'b010, 2'b10},
      '{OP_B,   3'b001, 1'b0, 1'b0, 0, 3, 0, 2, 0, 3'b010, 3'b001, 2'b10},
      '{OP_B,   3'b001, 1'b0, 1'b1, 0, 3, 0, 1, 0, 3'b010, 3'b001, 2'b10},
      '{OP_B,   3'b000, 1'b0, 1'b1, 0, 3, 0, 2, 0, 3'b010, 3'b001, 2'b10},
      '{OP_B,   3'b000, 1'b0, 1'b0, 0, 3, 0, 1, 0, 3'b010, 3'b001, 2'b10},
      '{OP_B,   3'b100, 1'b0, 1'b1, 0, 3, 0, 1, 0, 3'b010, 3'b001, 2'b10},
      '{OP_JAL, 3'b000, 1'b0, 1'b0, 0, 4, 1, 2, 0, 3'b011, 3'b000, 2'b01},
      '{OP_LUI, 3'b000, 1'b0, 1'b0, 0, 4, 1, 1, 0, 3'b100, 3'b000, 2'b11},
      '{OP_BAD, 3'b000, 1'b0, 1'b0, 0, 2, 0, 1, 0, 3'b000, 3'b000, 2'b00}
    };

    reset_n      = 1'b0;
    bus.op       = OP_LW;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_irw", 32'(bus.IRWrite), 32'd0);
    chk("rst_pcw", 32'(bus.PCWrite), 32'd0);
    chk("rst_ill", 32'(bus.IllegalInstr), 32'd0);
    chk("rst_fetch", 32'(bus.ResultSrc), 32'd2);
    chk("rst_wr", 32'({bus.MemWrite, bus.RegWrite}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vt[k]) run_vec(vt[k], k);

    // Illegal opcode: single-cycle flag, no writes outside FETCH
    bus.op       = OP_BAD;
    bus.funct3   = 3'b000;
    bus.MemReady = 1'b1;
    #1;
    chk("ill_prev_pulse", 32'(bus.IllegalInstr), 32'd1);
    @(negedge clk); #1;
    chk("ill_dec_flag", 32'(bus.IllegalInstr), 32'd0);
    chk("ill_dec_wr", 32'({bus.RegWrite, bus.MemWrite, bus.PCWrite}),
        32'd0);
    @(negedge clk); #1;
    chk("ill_pulse", 32'(bus.IllegalInstr), 32'd1);
    chk("ill_fetch", 32'(bus.ResultSrc), 32'd2);
    @(negedge clk); #1;
    chk("ill_pulse_end", 32'(bus.IllegalInstr), 32'd0);
    @(negedge clk);

    // Store aborted by reset while waiting in MEMWRITE
    bus.op = OP_SW;
    bus.MemReady = 1'b1;
    repeat (3) @(negedge clk);
    bus.MemReady = 1'b0;
    #1;
    chk("memw_wait0", 32'(bus.MemWrite), 32'd1);
    @(negedge clk); #1;
    chk("memw_wait1", 32'({bus.MemWrite, bus.AdrSrc}), 32'd3);
    #2;
    reset_n = 1'b0;
    bus.MemReady = 1'b1;
    #1;
    chk("abort_memw", 32'(bus.MemWrite), 32'd0);
    chk("abort_en", 32'({bus.IRWrite, bus.PCWrite, bus.RegWrite}), 32'd0);
    chk("abort_fetch", 32'(bus.ResultSrc), 32'd2);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("release_irw", 32'(bus.IRWrite), 32'd1);
    chk("release_pcw", 32'(bus.PCWrite), 32'd1);
    chk("release_memw", 32'(bus.MemWrite), 32'd0);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    ill_pend = 1'b0;

    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_I;
        4: op = OP_B;
        5: op = OP_JAL;
        6: op = OP_LUI;
        default: op = 7'($urandom_range(0, 127));
      endcase
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      build(op, f3, f7, z, $urandom_range(0, 2), $urandom_range(0, 3));
      run_q(op, f3, f7, z);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
